sample_reader: RTL

- Downstream stage of the sampling memory. On command, reads every stored sample and streams it out as a framed byte sequence over the shared UART transmitter.
- Fills the ST_SAMPLE_READ slot of the top-level state watcher, using the same activate/done contract as the sampler, replayer and reply_cnt blocks.
- Drives the memory read port (addr_out/oe) and the tx_data/tx_start inputs of the UART TX manager.

---
 rtl/sample_reader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sample_reader.sv
// Streams a framed dump of the sample memory (header, samples, optional XOR
// checksum) through the shared UART transmitter while activate is held.
module sample_reader #(
  parameter int          ADDR_WIDTH    = 8,
  parameter int          DEPTH         = 256,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter bit          SEND_CHECKSUM = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [7:0]            mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_SMP, PH_CHK} phase_t;

  // One extra counter bit so a full 2^ADDR_WIDTH frame still terminates.
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [7:0]            chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  done_q, done_d;
  logic                  mem_oe_q, mem_oe_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    count_d    = count_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (activate) begin
          addr_d  = '0;
          count_d = '0;
          chk_d   = '0;
          phase_d = PH_HDR;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        case (phase_q)
          PH_HDR:  tx_data_d = HEADER;
          PH_SMP: begin
            tx_data_d = mem_data;
            chk_d     = chk_q ^ mem_data;
          end
          PH_CHK:  tx_data_d = chk_q;
          default: tx_data_d = HEADER;
        endcase
        state_d = S_ARM;
      end
      S_ARM: begin
        if (!tx_active) begin
          tx_start_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only tx_done advances; tx_active may rise late behind the TX manager.
        if (tx_done) begin
          state_d = S_LOAD;
          case (phase_q)
            PH_HDR: phase_d = PH_SMP;
            PH_SMP: begin
              if (count_q < LAST) begin
                count_d = count_q + 1'b1;
                addr_d  = addr_q + 1'b1;
              end else if (SEND_CHECKSUM) begin
                phase_d = PH_CHK;
              end else begin
                state_d = S_DONE;
              end
            end
            PH_CHK:  state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        if (!activate) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !activate) begin
      state_d    = S_IDLE;
      tx_start_d = 1'b0;
    end

    done_d   = (state_d == S_DONE);
    mem_oe_d = (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_HDR;
      count_q    <= '0;
      chk_q      <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      mem_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      mem_oe_q   <= mem_oe_d;
    end
  end

  assign done     = done_q;
  assign mem_addr = addr_q;
  assign mem_oe   = mem_oe_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule
